l2_msg_ingress: RTL and testbench
=================================

# l2_msg_ingress

Ingress stage in front of the PMESH L2 message-processing pipeline. It accepts request messages on channel msg1 and writeback/response messages on channel msg3, buffers each channel in a small FIFO, and presents one message per handshake to the L2 pipeline. Writebacks (type 8'h0C, WB_REQ) are prioritised so the pipeline can always drain them. Requests are gated while the pipeline holds an open transaction, and a starvation counter keeps msg1 from being locked out.

## Interface
Parameters:
- DEPTH, 2: entries per channel FIFO; power of two, ≥2.
- STARVE_MAX, 4: consecutive msg3 grants while msg1 is eligible before msg1 is forced.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- msg1_valid / msg1_ready  in / out  1 / 1  request channel handshake.
- msg1_type, msg1_source, msg1_tag, msg1_data  in  8, 6, 26, 64  request payload.
- msg3_valid / msg3_ready  in / out  1 / 1  writeback channel handshake.
- msg3_type, msg3_source, msg3_tag, msg3_data  in  8, 6, 26, 64  writeback payload.
- l2_busy  in  1  pipeline has an open transaction (cur_msg_state ≠ 0); blocks msg1 dispatch only.
- out_valid / out_ready  out / in  1 / 1  dispatch handshake to the pipeline.
- out_chan  out  1  source channel: 0 = msg1, 1 = msg3.
- out_type, out_source, out_tag, out_data  out  8, 6, 26, 64  dispatched payload.
- out_is_wb  out  1  out_type == 8'h0C.

## Operation
- Per channel: msgX_ready = !rst_q && fifo_count < DEPTH, where rst_q is a registered copy of rst. Readies are 0 during reset and in the first cycle after reset. A push occurs on msgX_valid && msgX_ready.
- Output register: one entry. The slot is free when !out_valid or (out_valid && out_ready).
- Eligibility: msg3 is eligible when its FIFO is non-empty. msg1 is eligible when its FIFO is non-empty and !l2_busy.
- Arbitration runs when the slot is free:
  - If msg3 is eligible and (starve_cnt < STARVE_MAX or msg1 is not eligible), grant msg3.
  - Otherwise, if msg1 is eligible, grant msg1.
  - The grant pops the FIFO head into the output register. out_chan and out_is_wb are set at the same time.
- starve_cnt (3 bits, saturating at STARVE_MAX):
  - Increments on a msg3 grant while msg1 is eligible.
  - Clears on a msg1 grant.
  - Holds otherwise.
- While out_valid && !out_ready, all out_* signals hold stable. l2_busy changes never retract an already-loaded msg1 entry.
- Type is not checked for legality. Any type on either channel is passed through; out_is_wb is informational.
- Reset values: out_valid 0; out_chan 0; out_type/source/tag/data 0; out_is_wb 0; both FIFOs empty; starve_cnt 0; msg1_ready 0; msg3_ready 0.
- Reset mid-operation: FIFO contents and the output entry are discarded; no partial message is emitted afterwards.

## Timing
- Latency: a push in cycle N is written at the end of N. The earliest grant is in cycle N+1, giving out_valid in cycle N+2. There is no bypass path.
- Throughput: one message per cycle when out_ready is held high and either FIFO is non-empty.
- Push and pop in the same cycle are legal at any count; the count is unchanged. A full FIFO deasserts ready, so no push-when-full occurs.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- out_ready low with both FIFOs full: both readies are 0, and the output holds indefinitely without loss.

## Structure
- Package l2_msg_pkg:
  - Constants TYPE_W=8, SRC_W=6, TAG_W=26, DATA_W=64, and MSG_WB_REQ=8'h0C.
  - Packed struct l2_msg_t {type, source, tag, data}.
- Sub-module l2_msg_fifo (parameter DEPTH, payload l2_msg_t). Ports: push, full, pop, empty, head. Instantiated twice.
- The top holds the arbiter, starve_cnt, and the output register.

## Test plan
- Reset release: msg*_ready is 0 through rst and one cycle after, then 1. Push msg3 {type 8'h0C, tag 26'h1234, data 64'hDEAD} at N → out_valid at N+2, out_chan=1, out_is_wb=1, payload exact.
- Priority: both FIFOs loaded in the same cycle, out_ready=1 → msg3 is dispatched first, msg1 next cycle.
- Starvation: msg3 continuously valid, msg1 holds one entry, l2_busy=0 → msg1 is dispatched after exactly 4 msg3 grants. starve_cnt returns to 0.
- l2_busy=1 with msg1 queued and msg3 empty → no dispatch. Deassert l2_busy → msg1 is dispatched the next cycle. msg3 still flows while busy.
- Backpressure: out_ready=0 for 10 cycles with 3 msg1 pushes attempted → 2 are buffered plus 1 in the output register, and msg1_ready drops. On release, 3 messages appear in order with identical payloads.
- Reset mid-stream with 2 entries queued → out_valid=0 the cycle after rst, and no stale message afterwards.

Source files
------------

// File: rtl/l2_msg_ingress_pkg.sv
// Shared types and constants for the L2 message ingress stage.
// Message payload layout matches the PMESH L2 pipeline message fields.
package l2_msg_pkg;

    localparam int TYPE_W = 8;
    localparam int SRC_W  = 6;
    localparam int TAG_W  = 26;
    localparam int DATA_W = 64;

    localparam logic [TYPE_W-1:0] MSG_WB_REQ = 8'h0C;

    typedef struct packed {
        logic [TYPE_W-1:0] msg_type;
        logic [SRC_W-1:0]  source;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } l2_msg_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_MSG1 = 2'd1,
        GNT_MSG3 = 2'd2
    } grant_e;

    function automatic logic is_wb(input logic [TYPE_W-1:0] msg_type);
        return msg_type == MSG_WB_REQ;
    endfunction

endpackage

// File: rtl/l2_msg_ingress_if.sv
// Handshake bundle between the message sources, the ingress stage and the L2 pipeline.
// master = traffic/pipeline side, slave = ingress stage.
interface l2_msg_ingress_if;
    import l2_msg_pkg::*;

    logic              msg1_valid;
    logic              msg1_ready;
    logic [TYPE_W-1:0] msg1_type;
    logic [SRC_W-1:0]  msg1_source;
    logic [TAG_W-1:0]  msg1_tag;
    logic [DATA_W-1:0] msg1_data;

    logic              msg3_valid;
    logic              msg3_ready;
    logic [TYPE_W-1:0] msg3_type;
    logic [SRC_W-1:0]  msg3_source;
    logic [TAG_W-1:0]  msg3_tag;
    logic [DATA_W-1:0] msg3_data;

    logic              l2_busy;

    logic              out_valid;
    logic              out_ready;
    logic              out_chan;
    logic [TYPE_W-1:0] out_type;
    logic [SRC_W-1:0]  out_source;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_data;
    logic              out_is_wb;

    modport master (
        output msg1_valid, msg1_type, msg1_source, msg1_tag, msg1_data,
        input  msg1_ready,
        output msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data,
        input  msg3_ready,
        output l2_busy,
        output out_ready,
        input  out_valid, out_chan, out_type, out_source, out_tag, out_data, out_is_wb
    );

    modport slave (
        input  msg1_valid, msg1_type, msg1_source, msg1_tag, msg1_data,
        output msg1_ready,
        input  msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data,
        output msg3_ready,
        input  l2_busy,
        input  out_ready,
        output out_valid, out_chan, out_type, out_source, out_tag, out_data, out_is_wb
    );

endinterface

// File: rtl/l2_msg_ingress_fifo.sv
// Per-channel message FIFO; DEPTH must be a power of two so pointers wrap naturally.
// Push when full and pop when empty are ignored.
module l2_msg_fifo
    import l2_msg_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  l2_msg_t i_push_msg,
    output logic    o_full,
    input  logic    i_pop,
    output logic    o_empty,
    output l2_msg_t o_head
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    l2_msg_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/l2_msg_ingress.sv
// Ingress stage for the L2 pipeline: buffers msg1/msg3, arbitrates with writeback
// priority plus a starvation guard for msg1, and drives a one-entry output register.
module l2_msg_ingress
    import l2_msg_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input logic             clk,
    input logic             rst,
    l2_msg_ingress_if.slave bus
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic    r_rst_q;
    logic    r_out_valid;
    logic    r_out_chan;
    logic    r_out_is_wb;
    l2_msg_t r_out_msg;
    logic [2:0] r_starve_cnt;

    l2_msg_t w_m1_in;
    l2_msg_t w_m3_in;
    l2_msg_t w_m1_head;
    l2_msg_t w_m3_head;
    logic    w_m1_full;
    logic    w_m1_empty;
    logic    w_m3_full;
    logic    w_m3_empty;
    logic    w_m1_push;
    logic    w_m3_push;
    logic    w_m1_pop;
    logic    w_m3_pop;
    logic    w_m1_elig;
    logic    w_m3_elig;
    logic    w_slot_free;
    grant_e  w_grant;

    // Readies stay low for one cycle after reset via the registered reset copy.
    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    assign bus.msg1_ready = !rst && !r_rst_q && !w_m1_full;
    assign bus.msg3_ready = !rst && !r_rst_q && !w_m3_full;

    assign w_m1_push = bus.msg1_valid && bus.msg1_ready;
    assign w_m3_push = bus.msg3_valid && bus.msg3_ready;

    assign w_m1_in = {bus.msg1_type, bus.msg1_source, bus.msg1_tag, bus.msg1_data};
    assign w_m3_in = {bus.msg3_type, bus.msg3_source, bus.msg3_tag, bus.msg3_data};

    l2_msg_fifo #(.DEPTH(DEPTH)) u_fifo_msg1 (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_m1_push),
        .i_push_msg (w_m1_in),
        .o_full     (w_m1_full),
        .i_pop      (w_m1_pop),
        .o_empty    (w_m1_empty),
        .o_head     (w_m1_head)
    );

    l2_msg_fifo #(.DEPTH(DEPTH)) u_fifo_msg3 (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_m3_push),
        .i_push_msg (w_m3_in),
        .o_full     (w_m3_full),
        .i_pop      (w_m3_pop),
        .o_empty    (w_m3_empty),
        .o_head     (w_m3_head)
    );

    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_m3_elig   = !w_m3_empty;
    assign w_m1_elig   = !w_m1_empty && !bus.l2_busy;

    // Writebacks win unless msg1 has already lost STARVE_MAX grants in a row.
    always_comb begin
        w_grant = GNT_NONE;
        if (w_slot_free) begin
            if (w_m3_elig && ((r_starve_cnt < STARVE_LIM) || !w_m1_elig)) begin
                w_grant = GNT_MSG3;
            end else if (w_m1_elig) begin
                w_grant = GNT_MSG1;
            end
        end
    end

    assign w_m3_pop = (w_grant == GNT_MSG3);
    assign w_m1_pop = (w_grant == GNT_MSG1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant == GNT_MSG1) begin
            r_starve_cnt <= '0;
        end else if ((w_grant == GNT_MSG3) && w_m1_elig && (r_starve_cnt < STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
        end
    end

    // The output entry only changes when the slot is free, so a stalled entry holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_chan  <= 1'b0;
            r_out_is_wb <= 1'b0;
            r_out_msg   <= '0;
        end else if (w_slot_free) begin
            r_out_valid <= (w_grant != GNT_NONE);
            if (w_grant == GNT_MSG3) begin
                r_out_msg   <= w_m3_head;
                r_out_chan  <= 1'b1;
                r_out_is_wb <= is_wb(w_m3_head.msg_type);
            end else if (w_grant == GNT_MSG1) begin
                r_out_msg   <= w_m1_head;
                r_out_chan  <= 1'b0;
                r_out_is_wb <= is_wb(w_m1_head.msg_type);
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_chan   = r_out_chan;
    assign bus.out_is_wb  = r_out_is_wb;
    assign bus.out_type   = r_out_msg.msg_type;
    assign bus.out_source = r_out_msg.source;
    assign bus.out_tag    = r_out_msg.tag;
    assign bus.out_data   = r_out_msg.data;

endmodule

// File: tb/tb_l2_msg_ingress.sv
// Scoreboard bench for l2_msg_ingress: a queue-based reference model predicts dispatches,
// a negedge monitor compares every cycle; directed scenarios precede a random phase.
module tb_l2_msg_ingress;
    import l2_msg_pkg::*;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic    chan;
        l2_msg_t msg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_msg_ingress_if bus_if();

    l2_msg_ingress #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    l2_msg_t     mq1[$];
    l2_msg_t     mq3[$];
    exp_t        exp_q[$];
    logic        hs_chan[$];
    logic [63:0] hs_data[$];
    logic        m_rst_q  = 1'b1;
    logic        m_ov     = 1'b0;
    int          m_starve = 0;
    bit          mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready(input int ch);
        int sz;
        sz = (ch == 1) ? mq1.size() : mq3.size();
        return !rst && !m_rst_q && (sz < DEPTH);
    endfunction

    function automatic l2_msg_t rand_msg();
        l2_msg_t m;
        m.msg_type = ($urandom_range(3) == 0) ? MSG_WB_REQ : 8'($urandom);
        m.source   = 6'($urandom);
        m.tag      = 26'($urandom);
        m.data     = {$urandom, $urandom};
        return m;
    endfunction

    // Reference model: a one-slot output plus two bounded queues, evaluated per clock.
    always @(posedge clk) begin
        bit      rdy1, rdy3, free, el1, el3, g1, g3;
        l2_msg_t in1, in3;
        exp_t    e;
        rdy1 = m_ready(1);
        rdy3 = m_ready(3);
        in1  = {bus_if.msg1_type, bus_if.msg1_source, bus_if.msg1_tag, bus_if.msg1_data};
        in3  = {bus_if.msg3_type, bus_if.msg3_source, bus_if.msg3_tag, bus_if.msg3_data};
        if (rst) begin
            mq1.delete();
            mq3.delete();
            exp_q.delete();
            m_ov     = 1'b0;
            m_starve = 0;
        end else begin
            free = !m_ov || bus_if.out_ready;
            el3  = mq3.size() > 0;
            el1  = (mq1.size() > 0) && !bus_if.l2_busy;
            g3   = free && el3 && ((m_starve < STARVE_MAX) || !el1);
            g1   = free && !g3 && el1;
            if (free) m_ov = g1 || g3;
            if (g3) begin
                e.chan = 1'b1;
                e.msg  = mq3.pop_front();
                exp_q.push_back(e);
                if (el1 && m_starve < STARVE_MAX) m_starve++;
            end
            if (g1) begin
                e.chan = 1'b0;
                e.msg  = mq1.pop_front();
                exp_q.push_back(e);
                m_starve = 0;
            end
            if (bus_if.msg1_valid && rdy1) mq1.push_back(in1);
            if (bus_if.msg3_valid && rdy3) mq3.push_back(in3);
        end
        m_rst_q = rst;
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("msg1_ready", bus_if.msg1_ready, m_ready(1));
            chk("msg3_ready", bus_if.msg3_ready, m_ready(3));
            chk("out_valid", bus_if.out_valid, m_ov);
            if (bus_if.out_valid && bus_if.out_ready) begin
                hs_chan.push_back(bus_if.out_chan);
                hs_data.push_back(bus_if.out_data);
                if (exp_q.size() == 0) begin
                    chk("unexpected_dispatch", 64'(bus_if.out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_chan", bus_if.out_chan, e.chan);
                    chk("out_type", bus_if.out_type, e.msg.msg_type);
                    chk("out_source", bus_if.out_source, e.msg.source);
                    chk("out_tag", bus_if.out_tag, e.msg.tag);
                    chk("out_data", bus_if.out_data, e.msg.data);
                    chk("out_is_wb", bus_if.out_is_wb, e.msg.msg_type == 8'h0C);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m1(input logic v, input l2_msg_t m);
        bus_if.msg1_valid  = v;
        bus_if.msg1_type   = m.msg_type;
        bus_if.msg1_source = m.source;
        bus_if.msg1_tag    = m.tag;
        bus_if.msg1_data   = m.data;
    endtask

    task automatic set_m3(input logic v, input l2_msg_t m);
        bus_if.msg3_valid  = v;
        bus_if.msg3_type   = m.msg_type;
        bus_if.msg3_source = m.source;
        bus_if.msg3_tag    = m.tag;
        bus_if.msg3_data   = m.data;
    endtask

    // Holds valid until a ready is seen before the edge; bounded wait.
    task automatic send(input int ch, input l2_msg_t m);
        bit ok;
        ok = 1'b0;
        if (ch == 1) set_m1(1'b1, m); else set_m3(1'b1, m);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = (ch == 1) ? bus_if.msg1_ready : bus_if.msg3_ready;
            step();
            if (ok) break;
        end
        if (ch == 1) bus_if.msg1_valid = 1'b0; else bus_if.msg3_valid = 1'b0;
        chk("send_accepted", 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        l2_msg_t m, sent[3];
        int s, pos;
        set_m1(1'b0, '0);
        set_m3(1'b0, '0);
        bus_if.l2_busy   = 1'b0;
        bus_if.out_ready = 1'b1;
        rst = 1'b1;

        step();
        mon_en = 1'b1;
        step();
        @(negedge clk);
        chk("ready_in_reset", bus_if.msg1_ready, 1'b0);
        chk("out_valid_reset", bus_if.out_valid, 1'b0);
        chk("out_chan_reset", bus_if.out_chan, 1'b0);
        chk("out_data_reset", bus_if.out_data, 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus_if.msg3_ready, 1'b0);
        step();
        @(negedge clk);
        chk("ready_released", bus_if.msg3_ready, 1'b1);

        // Latency: push at N, out_valid at N+2.
        step();
        m = '{msg_type: 8'h0C, source: 6'h0, tag: 26'h1234, data: 64'hDEAD};
        set_m3(1'b1, m);
        step();
        bus_if.msg3_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1_valid", bus_if.out_valid, 1'b0);
        step();
        @(negedge clk);
        chk("lat_n2_valid", bus_if.out_valid, 1'b1);
        chk("lat_chan", bus_if.out_chan, 1'b1);
        chk("lat_is_wb", bus_if.out_is_wb, 1'b1);
        chk("lat_tag", bus_if.out_tag, 26'h1234);
        chk("lat_data", bus_if.out_data, 64'hDEAD);
        repeat (3) step();

        // Priority: same-cycle load, msg3 first.
        s = hs_chan.size();
        set_m1(1'b1, rand_msg());
        set_m3(1'b1, rand_msg());
        step();
        set_m1(1'b0, '0);
        set_m3(1'b0, '0);
        repeat (4) step();
        chk("prio_count", hs_chan.size() - s, 2);
        if (hs_chan.size() >= s + 2) begin
            chk("prio_first", hs_chan[s], 1'b1);
            chk("prio_second", hs_chan[s+1], 1'b0);
        end

        // Starvation, twice to show the counter clears after a msg1 grant.
        for (int r = 0; r < 2; r++) begin
            s = hs_chan.size();
            set_m1(1'b1, rand_msg());
            set_m3(1'b1, rand_msg());
            step();
            bus_if.msg1_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                set_m3(1'b1, rand_msg());
                step();
            end
            bus_if.msg3_valid = 1'b0;
            repeat (6) step();
            pos = -1;
            for (int i = s; i < hs_chan.size(); i++) begin
                if (hs_chan[i] == 1'b0) begin
                    pos = i - s;
                    break;
                end
            end
            chk("starve_msg1_pos", 64'(pos), 64'd4);
        end

        // l2_busy blocks msg1 only.
        bus_if.l2_busy = 1'b1;
        send(1, rand_msg());
        repeat (5) step();
        @(negedge clk);
        chk("busy_blocks_msg1", bus_if.out_valid, 1'b0);
        step();
        s = hs_chan.size();
        send(3, rand_msg());
        repeat (4) step();
        chk("busy_msg3_flows", hs_chan.size() - s, 1);
        bus_if.l2_busy = 1'b0;
        @(negedge clk);
        chk("unbusy_same_cycle", bus_if.out_valid, 1'b0);
        step();
        @(negedge clk);
        chk("unbusy_dispatch", bus_if.out_valid, 1'b1);
        chk("unbusy_chan", bus_if.out_chan, 1'b0);
        repeat (3) step();

        // Backpressure: 3 msg1 held (2 in FIFO + 1 in output register).
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sent[i] = rand_msg();
            send(1, sent[i]);
        end
        repeat (10) step();
        @(negedge clk);
        chk("bp_ready_low", bus_if.msg1_ready, 1'b0);
        chk("bp_out_held", bus_if.out_valid, 1'b1);
        chk("bp_out_data", bus_if.out_data, sent[0].data);
        step();
        s = hs_chan.size();
        bus_if.out_ready = 1'b1;
        repeat (6) step();
        chk("bp_drain_count", hs_chan.size() - s, 3);
        if (hs_chan.size() >= s + 3) begin
            for (int i = 0; i < 3; i++) chk("bp_order", hs_data[s+i], sent[i].data);
        end

        // Reset with entries queued: nothing stale afterwards.
        bus_if.out_ready = 1'b0;
        send(3, rand_msg());
        send(3, rand_msg());
        send(1, rand_msg());
        repeat (3) step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rst_mid_out_valid", bus_if.out_valid, 1'b0);
        step();
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        s = hs_chan.size();
        repeat (10) step();
        chk("rst_mid_no_stale", hs_chan.size() - s, 0);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            set_m1($urandom_range(1) == 1, rand_msg());
            set_m3($urandom_range(4) < 2, rand_msg());
            bus_if.out_ready = $urandom_range(9) < 7;
            bus_if.l2_busy   = $urandom_range(3) == 0;
            rst              = $urandom_range(299) == 0;
            step();
        end
        rst = 1'b0;
        set_m1(1'b0, '0);
        set_m3(1'b0, '0);
        bus_if.out_ready = 1'b1;
        bus_if.l2_busy   = 1'b0;
        repeat (12) step();
        @(negedge clk);
        chk("drain_out_valid", bus_if.out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
